level_loader: RTL
=================

# level_loader

Sequences the obstacle-configuration datapath whenever the game enters a new level. While the game controller holds `reset_level`, this block reads the per-level obstacle layout from an internal ROM and writes it into the obstacle register bank through a valid/ready write port, one obstacle per beat. Writes start only at a frame boundary, so the drawn playfield never tears. It reports `level_ready` once the bank holds the layout for the current `level`.

## Interface
- `NUM_OBSTACLES`, default 8: obstacles per level; power of two, ≥2.
- `LEVEL_COUNT`, default 4: distinct layouts in ROM; power of two. Levels wrap modulo this value.
- `COORD_W`, default 11: pixel coordinate width.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `reset_level` in 1: level-setup request from the game controller; high while the game is paused for setup.
- `level` in 4: current level number.
- `startOfFrame` in 1: one-cycle pulse at the start of vertical blank.
- `wr_ready` in 1: obstacle bank accepts the current beat.
- `wr_valid` out 1: write beat present.
- `wr_index` out log2(NUM_OBSTACLES): obstacle slot being written.
- `wr_topLeftX` out COORD_W: obstacle X position.
- `wr_topLeftY` out COORD_W: obstacle Y position.
- `wr_enable` out 1: the obstacle slot is active (drawn and collidable).
- `loading` out 1: high in any state other than IDLE.
- `level_ready` out 1: the bank holds the layout for `level`.

## Operation
- FSM states: IDLE, WAIT_FRAME, WRITE, DONE. Internal registers: `load_level`, `loaded_level`, `loaded_valid`, `index`.
- **IDLE**
  - A trigger is `reset_level` high together with either `!loaded_valid` or `level != loaded_level`.
  - On a trigger: `load_level <= level`, then go to WAIT_FRAME.
  - With no trigger, stay in IDLE. A repeated `reset_level` for an already-loaded level performs no writes.
- **WAIT_FRAME**
  - If `level != load_level`, re-latch `load_level` and keep waiting.
  - On `startOfFrame`: `index <= 0`, then go to WRITE.
- **WRITE**
  - Drive `wr_valid = 1`, with `wr_index = index` and ROM data for (`load_level mod LEVEL_COUNT`, `index`).
  - Data and index stay stable while `wr_ready` is low.
  - On `wr_valid && wr_ready`:
    - If `index == NUM_OBSTACLES-1`, go to DONE.
    - Otherwise increment `index`.
- **DONE** (one cycle): `loaded_level <= load_level`, `loaded_valid <= 1`, then go to IDLE.
- `level_ready = (state == IDLE) && loaded_valid && (loaded_level == level)`. It is combinational from registers and `level`.
- A `level` change during WRITE does not abort the load. The load completes, and IDLE then re-triggers on the mismatch if `reset_level` is still high.
- `reset_level` falling mid-load does not abort the load either. Layout integrity takes priority.
- Reset values:
  - State IDLE; all outputs 0.
  - `index`, `load_level`, `loaded_level` = 0; `loaded_valid` = 0.
- Reset mid-load returns to IDLE immediately. `loaded_valid` clears, so the next `reset_level` reloads.

## Timing
- Cycle T: trigger sampled in IDLE. T+1: WAIT_FRAME.
- The first `startOfFrame` sampled in WAIT_FRAME at cycle F causes WRITE at F+1, and `wr_valid` is high from F+1.
- With `wr_ready` tied high, beats occur on cycles F+1 … F+NUM_OBSTACLES. DONE follows at F+NUM_OBSTACLES+1, and `level_ready` is high from F+NUM_OBSTACLES+2.
- A `startOfFrame` arriving in the same cycle as the trigger in IDLE is ignored. The block waits for the next frame.
- All outputs except `level_ready` are registered.

## Structure
- Shared package:
  - the `level_loader_state_t` enum;
  - the obstacle entry struct `{x, y, enable}`;
  - `NUM_OBSTACLES`, `LEVEL_COUNT` and `COORD_W` defaults, alongside the existing `LIFE_INIT`.
- Sub-module `level_rom`: a combinational lookup from (level mod LEVEL_COUNT, index) to the obstacle entry.
- The FSM, counter and handshake live in `level_loader`.

## Test plan
- Reset, then hold `reset_level=1` with `level=0`, pulse `startOfFrame`, and tie `wr_ready=1`:
  - expect 8 beats, `wr_index` 0..7, matching the ROM for level 0;
  - expect `level_ready=1` at F+10 and `loading=0`.
- After loading level 0, raise `reset_level` again with `level=0` → no `wr_valid`, and `level_ready` stays 1.
- With `level=5` and `LEVEL_COUNT=4` → the ROM data for layout 1 is written, and `loaded_level=5`.
- Toggle `wr_ready` 1,0,0,1… during WRITE → each beat holds stable data while stalled, there are exactly 8 accepted beats, and none are duplicated.
- Change `level` from 1 to 2 at beat 3 of a level-1 load, with `reset_level` held:
  - level 1 completes with 8 beats;
  - a level-2 load follows after the next `startOfFrame`;
  - `level_ready` stays 0 until the level-2 load has finished.
- Assert `resetN=0` at beat 4 → `wr_valid`=0 and `loading`=0 immediately. The next `reset_level` restarts from index 0.

Source files
------------

// File: rtl/level_loader_pkg.sv
// Shared types and default parameters for the level-setup datapath.
package level_loader_pkg;

  localparam int unsigned NUM_OBSTACLES_DEF = 8;
  localparam int unsigned LEVEL_COUNT_DEF   = 4;
  localparam int unsigned COORD_W_DEF       = 11;
  localparam int unsigned LEVEL_W           = 4;
  localparam int unsigned LIFE_INIT         = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    WRITE,
    DONE
  } level_loader_state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic                   enable;
  } obstacle_t;

endpackage

// File: rtl/level_loader_if.sv
// Valid/ready write port into the obstacle register bank.
interface level_loader_if
  import level_loader_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES = NUM_OBSTACLES_DEF,
  parameter int unsigned COORD_W       = COORD_W_DEF
);
  localparam int unsigned IDX_W = $clog2(NUM_OBSTACLES);

  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_index;
  logic [COORD_W-1:0] wr_topLeftX;
  logic [COORD_W-1:0] wr_topLeftY;
  logic               wr_enable;

  modport master (
    output wr_valid, wr_index, wr_topLeftX, wr_topLeftY, wr_enable,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_index, wr_topLeftX, wr_topLeftY, wr_enable,
    output wr_ready
  );
endinterface

// File: rtl/level_loader_rom.sv
// Combinational obstacle layout table, indexed by (level mod LEVEL_COUNT, slot).
module level_rom
  import level_loader_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES = NUM_OBSTACLES_DEF,
  parameter int unsigned LEVEL_COUNT   = LEVEL_COUNT_DEF,
  parameter int unsigned COORD_W       = COORD_W_DEF,
  localparam int unsigned IDX_W        = $clog2(NUM_OBSTACLES)
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic [IDX_W-1:0]   index,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               enable
);

  logic [31:0] layout;
  logic [31:0] slot;
  logic [7:0]  mask;

  always_comb begin
    layout = 32'(level) % LEVEL_COUNT;
    slot   = 32'(index);
    x      = '0;
    y      = '0;
    mask   = '0;
    case (layout)
      32'd0: begin
        x    = COORD_W'(32'd32 + 32'd64 * slot);
        y    = COORD_W'(32'd64);
        mask = 8'hFF;
      end
      32'd1: begin
        x    = COORD_W'(32'd100 + 32'd48 * slot);
        y    = COORD_W'(32'd96 + 32'd16 * slot);
        mask = 8'h7F;
      end
      32'd2: begin
        x    = COORD_W'(32'd50 + 32'd70 * slot);
        y    = COORD_W'(32'd200 + (slot[0] ? 32'd40 : 32'd0));
        mask = 8'hAA;
      end
      default: begin
        x    = COORD_W'(32'd600 - 32'd40 * slot);
        y    = COORD_W'(32'd300 - 32'd20 * slot);
        mask = 8'h55;
      end
    endcase
    // Enable pattern repeats every 8 slots for larger obstacle counts.
    enable = mask[slot[2:0]];
  end

endmodule

// File: rtl/level_loader.sv
// Loads the per-level obstacle layout into the obstacle bank, starting on a frame boundary.
module level_loader
  import level_loader_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES = NUM_OBSTACLES_DEF,
  parameter int unsigned LEVEL_COUNT   = LEVEL_COUNT_DEF,
  parameter int unsigned COORD_W       = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               reset_level,
  input  logic [LEVEL_W-1:0] level,
  input  logic               startOfFrame,
  level_loader_if.master     wr,
  output logic               loading,
  output logic               level_ready
);

  localparam int unsigned      IDX_W = $clog2(NUM_OBSTACLES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_OBSTACLES - 1);

  level_loader_state_t state, state_n;
  logic [IDX_W-1:0]    index, index_n;
  logic [LEVEL_W-1:0]  load_level, load_level_n;
  logic [LEVEL_W-1:0]  loaded_level, loaded_level_n;
  logic                loaded_valid, loaded_valid_n;

  logic [COORD_W-1:0]  rom_x;
  logic [COORD_W-1:0]  rom_y;
  logic                rom_enable;

  // Addressed by next-state values so the registered beat lines up with the state.
  level_rom #(
    .NUM_OBSTACLES(NUM_OBSTACLES),
    .LEVEL_COUNT  (LEVEL_COUNT),
    .COORD_W      (COORD_W)
  ) u_rom (
    .level (load_level_n),
    .index (index_n),
    .x     (rom_x),
    .y     (rom_y),
    .enable(rom_enable)
  );

  always_comb begin
    state_n        = state;
    index_n        = index;
    load_level_n   = load_level;
    loaded_level_n = loaded_level;
    loaded_valid_n = loaded_valid;
    unique case (state)
      IDLE: begin
        if (reset_level && (!loaded_valid || level != loaded_level)) begin
          load_level_n = level;
          state_n      = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (level != load_level) load_level_n = level;
        if (startOfFrame) begin
          index_n = '0;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (wr.wr_valid && wr.wr_ready) begin
          if (index == LAST) state_n = DONE;
          else               index_n = index + 1'b1;
        end
      end
      DONE: begin
        loaded_level_n = load_level;
        loaded_valid_n = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      index          <= '0;
      load_level     <= '0;
      loaded_level   <= '0;
      loaded_valid   <= 1'b0;
      wr.wr_valid    <= 1'b0;
      wr.wr_index    <= '0;
      wr.wr_topLeftX <= '0;
      wr.wr_topLeftY <= '0;
      wr.wr_enable   <= 1'b0;
      loading        <= 1'b0;
    end else begin
      state        <= state_n;
      index        <= index_n;
      load_level   <= load_level_n;
      loaded_level <= loaded_level_n;
      loaded_valid <= loaded_valid_n;
      loading      <= (state_n != IDLE);
      wr.wr_valid  <= (state_n == WRITE);
      if (state_n == WRITE) begin
        wr.wr_index    <= index_n;
        wr.wr_topLeftX <= rom_x;
        wr.wr_topLeftY <= rom_y;
        wr.wr_enable   <= rom_enable;
      end else begin
        wr.wr_index    <= '0;
        wr.wr_topLeftX <= '0;
        wr.wr_topLeftY <= '0;
        wr.wr_enable   <= 1'b0;
      end
    end
  end

  assign level_ready = (state == IDLE) && loaded_valid && (loaded_level == level);

endmodule
